// File: rtl/clock_mode_ctrl_pkg.sv
// Shared constants for the HMS clock mode/setup controller: mode and position
// encodings, blink-pair bit offsets and small position helpers.
package clock_mode_ctrl_pkg;

  typedef enum logic {
    MODE_CLOCK = 1'b0,
    MODE_SETUP = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_e;

  localparam int unsigned BLINK_SEC_LSB  = 0;
  localparam int unsigned BLINK_MIN_LSB  = 2;
  localparam int unsigned BLINK_HOUR_LSB = 4;

  function automatic pos_e next_pos(input pos_e p);
    case (p)
      POS_SEC: return POS_MIN;
      POS_MIN: return POS_HOUR;
      default: return POS_SEC;
    endcase
  endfunction

  function automatic logic [5:0] blink_mask(input pos_e p);
    logic [5:0] m;
    m = '0;
    case (p)
      POS_SEC:  m[BLINK_SEC_LSB  +: 2] = '1;
      POS_MIN:  m[BLINK_MIN_LSB  +: 2] = '1;
      POS_HOUR: m[BLINK_HOUR_LSB +: 2] = '1;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// Bus between the mode controller and the HMS counter/display datapath.
// master = controller side, slave = datapath side.
interface clock_mode_ctrl_if;
  logic       i_tick_1hz;
  logic       i_sec_at_max;
  logic       i_min_at_max;
  logic       o_mode;
  logic [1:0] o_position;
  logic       o_sec_inc;
  logic       o_min_inc;
  logic       o_hour_inc;
  logic [5:0] o_blink_enb;

  modport master (
    input  i_tick_1hz, i_sec_at_max, i_min_at_max,
    output o_mode, o_position, o_sec_inc, o_min_inc, o_hour_inc, o_blink_enb
  );

  modport slave (
    output i_tick_1hz, i_sec_at_max, i_min_at_max,
    input  o_mode, o_position, o_sec_inc, o_min_inc, o_hour_inc, o_blink_enb
  );
endinterface

// File: rtl/sw_debounce_edge.sv
// Active-low push-button cleaner: 2-FF synchronizer, consecutive-sample
// debounce and a one-cycle press pulse on the debounced 1->0 transition.
module sw_debounce_edge #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sw_n,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned    CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds how many differing samples preceded this one; the
  // DEB_CYCLES-th consecutive differing sample commits the new level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= i_sw_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign o_level = level_q;
  assign o_press = press_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// CLOCK/SETUP mode controller for the HMS clock: button cleaning, increment
// enables and digit-blink mask. Optional auto-repeat: CLOCK_CTRL_AUTOREPEAT_EN.
module clock_mode_ctrl
  import clock_mode_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned BLINK_HALF = 12500000,
  parameter int unsigned REPEAT_DLY = 25000000,
  parameter int unsigned REPEAT_PER = 5000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_sw0,
  input  logic               i_sw1,
  input  logic               i_sw2,
  clock_mode_ctrl_if.master  bus
);

`ifdef CLOCK_CTRL_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  localparam int unsigned   BW         = $clog2(BLINK_HALF);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam int unsigned   RW         = $clog2(REPEAT_DLY);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DLY - REPEAT_PER);

  logic sw0_press, sw1_press, sw2_press;
  logic sw2_level;
  logic sw0_level_unused, sw1_level_unused;

  sw_debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sw0 (
    .clk(clk), .rst_n(rst_n), .i_sw_n(i_sw0), .o_level(sw0_level_unused), .o_press(sw0_press)
  );
  sw_debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sw1 (
    .clk(clk), .rst_n(rst_n), .i_sw_n(i_sw1), .o_level(sw1_level_unused), .o_press(sw1_press)
  );
  sw_debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sw2 (
    .clk(clk), .rst_n(rst_n), .i_sw_n(i_sw2), .o_level(sw2_level), .o_press(sw2_press)
  );

  mode_e         state_q, state_d;
  pos_e          pos_q, pos_d;
  logic          sec_inc_q, sec_inc_d;
  logic          min_inc_q, min_inc_d;
  logic          hour_inc_q, hour_inc_d;
  logic [5:0]    blink_q, blink_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_arm_q, rep_arm_d;
  logic          restart;
  logic          inc_sel;

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    sec_inc_d  = 1'b0;
    min_inc_d  = 1'b0;
    hour_inc_d = 1'b0;
    rep_cnt_d  = '0;
    rep_arm_d  = 1'b0;
    restart    = 1'b0;
    inc_sel    = 1'b0;

    case (state_q)
      MODE_CLOCK: begin
        sec_inc_d  = bus.i_tick_1hz;
        min_inc_d  = bus.i_tick_1hz & bus.i_sec_at_max;
        hour_inc_d = bus.i_tick_1hz & bus.i_sec_at_max & bus.i_min_at_max;
        if (sw0_press) begin
          state_d = MODE_SETUP;
          pos_d   = POS_SEC;
          restart = 1'b1;
        end
      end
      MODE_SETUP: begin
        if (sw0_press) begin
          state_d = MODE_CLOCK;
          restart = 1'b1;
        end else begin
          if (sw2_press) begin
            inc_sel   = 1'b1;
            rep_arm_d = AUTOREPEAT;
          end else if (rep_arm_q && !sw2_level) begin
            rep_arm_d = 1'b1;
            if (rep_cnt_q == REP_LAST) begin
              inc_sel   = 1'b1;
              rep_cnt_d = REP_RELOAD;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
          // Increment (above) targets the old position; advancing comes after.
          if (sw1_press) begin
            pos_d     = next_pos(pos_q);
            restart   = 1'b1;
            rep_arm_d = 1'b0;
            rep_cnt_d = '0;
          end
        end
      end
      default: state_d = MODE_CLOCK;
    endcase

    if (inc_sel) begin
      case (pos_q)
        POS_SEC:  sec_inc_d  = 1'b1;
        POS_MIN:  min_inc_d  = 1'b1;
        POS_HOUR: hour_inc_d = 1'b1;
        default:  ;
      endcase
    end

    blink_cnt_d = '0;
    phase_d     = 1'b0;
    if (state_d == MODE_SETUP && !restart) begin
      if (blink_cnt_q == BLINK_LAST) begin
        phase_d = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
      end
    end
    blink_d = phase_d ? blink_mask(pos_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MODE_CLOCK;
      pos_q       <= POS_SEC;
      sec_inc_q   <= 1'b0;
      min_inc_q   <= 1'b0;
      hour_inc_q  <= 1'b0;
      blink_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      rep_cnt_q   <= '0;
      rep_arm_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      sec_inc_q   <= sec_inc_d;
      min_inc_q   <= min_inc_d;
      hour_inc_q  <= hour_inc_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_arm_q   <= rep_arm_d;
    end
  end

  assign bus.o_mode      = state_q;
  assign bus.o_position  = pos_q;
  assign bus.o_sec_inc   = sec_inc_q;
  assign bus.o_min_inc   = min_inc_q;
  assign bus.o_hour_inc  = hour_inc_q;
  assign bus.o_blink_enb = blink_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with short debounce/blink/repeat timings.
`timescale 1ns/1ps
module tb_clock_mode_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic sw0   = 1'b1;
  logic sw1   = 1'b1;
  logic sw2   = 1'b1;

  int tests = 0;
  int fails = 0;

  int n_sec = 0, n_min = 0, n_hour = 0, n_double = 0;
  logic prev_sec = 1'b0, prev_min = 1'b0, prev_hour = 1'b0;

  clock_mode_ctrl_if bus ();

  clock_mode_ctrl #(
    .DEB_CYCLES(4),
    .BLINK_HALF(8),
    .REPEAT_DLY(20),
    .REPEAT_PER(5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_sw0 (sw0),
    .i_sw1 (sw1),
    .i_sw2 (sw2),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulse tally sampled on the falling edge, away from output updates.
  always @(negedge clk) begin
    if (rst_n) begin
      n_sec  += int'(bus.o_sec_inc);
      n_min  += int'(bus.o_min_inc);
      n_hour += int'(bus.o_hour_inc);
      if ((bus.o_sec_inc && prev_sec) || (bus.o_min_inc && prev_min) ||
          (bus.o_hour_inc && prev_hour))
        n_double++;
    end
    prev_sec  = bus.o_sec_inc;
    prev_min  = bus.o_min_inc;
    prev_hour = bus.o_hour_inc;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_sw(input int which);
    case (which)
      0: sw0 = 1'b0;
      1: sw1 = 1'b0;
      default: sw2 = 1'b0;
    endcase
    step(8);
    sw0 = 1'b1; sw1 = 1'b1; sw2 = 1'b1;
    step(8);
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    tests++; if (bus.o_mode !== 1'b0) begin fails++; $display("FAIL reset_mode: got %0b want 0", bus.o_mode); end
    tests++; if (bus.o_position !== 2'd0) begin fails++; $display("FAIL reset_pos: got %0d want 0", bus.o_position); end
    tests++; if ({bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc} !== 3'b000) begin
      fails++; $display("FAIL reset_inc: got %b want 000", {bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc}); end
    tests++; if (bus.o_blink_enb !== 6'b0) begin fails++; $display("FAIL reset_blink: got %b want 000000", bus.o_blink_enb); end
    step(3);
    rst_n = 1'b1;
    step(3);
    tests++; if (bus.o_mode !== 1'b0) begin fails++; $display("FAIL post_reset_mode: got %0b want 0", bus.o_mode); end
  endtask

  task automatic test_tick_clock;
    logic [2:0] got;
    bus.i_sec_at_max = 1'b1; bus.i_min_at_max = 1'b1; bus.i_tick_1hz = 1'b1;
    step(1); bus.i_tick_1hz = 1'b0;
    got = {bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc};
    tests++; if (got !== 3'b111) begin fails++; $display("FAIL tick_full_carry: got %b want 111", got); end
    step(1);
    got = {bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc};
    tests++; if (got !== 3'b000) begin fails++; $display("FAIL tick_one_cycle: got %b want 000", got); end
    bus.i_min_at_max = 1'b0; bus.i_tick_1hz = 1'b1;
    step(1); bus.i_tick_1hz = 1'b0;
    got = {bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc};
    tests++; if (got !== 3'b110) begin fails++; $display("FAIL tick_sec_carry: got %b want 110", got); end
    bus.i_sec_at_max = 1'b0; bus.i_min_at_max = 1'b1;
    step(2); bus.i_tick_1hz = 1'b1;
    step(1); bus.i_tick_1hz = 1'b0;
    got = {bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc};
    tests++; if (got !== 3'b100) begin fails++; $display("FAIL tick_no_carry: got %b want 100", got); end
    bus.i_min_at_max = 1'b0;
    step(2);
  endtask

  task automatic test_debounce_mode;
    int rises;
    logic pm;
    sw0 = 1'b0; step(3); sw0 = 1'b1; step(12);
    tests++; if (bus.o_mode !== 1'b0) begin fails++; $display("FAIL short_glitch_mode: got %0b want 0", bus.o_mode); end
    rises = 0; pm = bus.o_mode;
    sw0 = 1'b0;
    for (int i = 0; i < 10; i++) begin step(1); if (bus.o_mode && !pm) rises++; pm = bus.o_mode; end
    sw0 = 1'b1;
    for (int i = 0; i < 12; i++) begin step(1); if (bus.o_mode && !pm) rises++; pm = bus.o_mode; end
    tests++; if (rises != 1) begin fails++; $display("FAIL enter_setup_once: got %0d rises want 1", rises); end
    tests++; if (bus.o_mode !== 1'b1) begin fails++; $display("FAIL enter_setup_mode: got %0b want 1", bus.o_mode); end
    tests++; if (bus.o_position !== 2'd0) begin fails++; $display("FAIL enter_setup_pos: got %0d want 0", bus.o_position); end
  endtask

  task automatic test_setup_select;
    int bs, bm, bh;
    press_sw(1);
    press_sw(1);
    tests++; if (bus.o_position !== 2'd2) begin fails++; $display("FAIL select_pos: got %0d want 2", bus.o_position); end
    bs = n_sec; bm = n_min; bh = n_hour;
    press_sw(2);
    tests++; if (n_hour - bh != 1) begin fails++; $display("FAIL setup_hour_inc: got %0d want 1", n_hour - bh); end
    tests++; if ((n_sec - bs) + (n_min - bm) != 0) begin
      fails++; $display("FAIL setup_other_inc: got %0d want 0", (n_sec - bs) + (n_min - bm)); end
    bs = n_sec; bm = n_min; bh = n_hour;
    bus.i_sec_at_max = 1'b1; bus.i_min_at_max = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.i_tick_1hz = 1'b1; step(1); bus.i_tick_1hz = 1'b0; step(3);
    end
    bus.i_sec_at_max = 1'b0; bus.i_min_at_max = 1'b0;
    tests++; if ((n_sec - bs) + (n_min - bm) + (n_hour - bh) != 0) begin
      fails++; $display("FAIL setup_ticks_frozen: got %0d pulses want 0", (n_sec - bs) + (n_min - bm) + (n_hour - bh)); end
  endtask

  task automatic test_blink;
    logic found;
    logic [5:0] exp;
    press_sw(1);
    tests++; if (bus.o_position !== 2'd0) begin fails++; $display("FAIL wrap_pos: got %0d want 0", bus.o_position); end
    sw1 = 1'b0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin step(1); if (bus.o_position == 2'd1) found = 1'b1; end
    sw1 = 1'b1;
    tests++; if (!found) begin fails++; $display("FAIL blink_pos_timeout: got 0 want 1"); end
    for (int i = 0; i < 24; i++) begin
      if (i % 8 == 0 || i % 8 == 7) begin
        exp = ((i / 8) % 2 == 1) ? 6'b001100 : 6'b000000;
        tests++; if (bus.o_blink_enb !== exp) begin
          fails++; $display("FAIL blink_min_c%0d: got %b want %b", i, bus.o_blink_enb, exp); end
      end
      step(1);
    end
    sw0 = 1'b0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin step(1); if (bus.o_mode == 1'b0) found = 1'b1; end
    tests++; if (!found || bus.o_blink_enb !== 6'b0) begin
      fails++; $display("FAIL exit_blink_clear: got %b want 000000 (mode_seen=%0b)", bus.o_blink_enb, found); end
    tests++; if (bus.o_position !== 2'd1) begin fails++; $display("FAIL exit_pos_kept: got %0d want 1", bus.o_position); end
    sw0 = 1'b1; step(8);
  endtask

  task automatic test_back_to_back;
    int bs, bm, bh;
    press_sw(0);
    tests++; if (bus.o_mode !== 1'b1) begin fails++; $display("FAIL b2b_enter: got %0b want 1", bus.o_mode); end
    bs = n_sec; bm = n_min; bh = n_hour;
    sw0 = 1'b0; sw2 = 1'b0; step(8); sw0 = 1'b1; sw2 = 1'b1; step(8);
    tests++; if (bus.o_mode !== 1'b0) begin fails++; $display("FAIL sw0_sw2_mode: got %0b want 0", bus.o_mode); end
    tests++; if ((n_sec - bs) + (n_min - bm) + (n_hour - bh) != 0) begin
      fails++; $display("FAIL sw0_sw2_noinc: got %0d want 0", (n_sec - bs) + (n_min - bm) + (n_hour - bh)); end
    bs = n_sec;
    sw0 = 1'b0; step(6);
    bus.i_tick_1hz = 1'b1; step(1); bus.i_tick_1hz = 1'b0;
    tests++; if (bus.o_mode !== 1'b1 || bus.o_sec_inc !== 1'b1) begin
      fails++; $display("FAIL tick_on_entry: got mode=%0b sec_inc=%0b want 1 1", bus.o_mode, bus.o_sec_inc); end
    sw0 = 1'b1; step(8);
    tests++; if (n_sec - bs != 1) begin fails++; $display("FAIL tick_on_entry_count: got %0d want 1", n_sec - bs); end
  endtask

  task automatic test_reset_mid;
    int bs, bm, bh;
    logic found;
    sw2 = 1'b0; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin step(1); if (bus.o_blink_enb != 6'b0) found = 1'b1; end
    tests++; if (!found) begin fails++; $display("FAIL mid_blink_timeout: got 0 want 1"); end
    #3 rst_n = 1'b0;
    #1;
    tests++; if ({bus.o_mode, bus.o_position, bus.o_blink_enb} !== 9'b0) begin
      fails++; $display("FAIL async_reset: got mode=%0b pos=%0d blink=%b want 0 0 000000",
                        bus.o_mode, bus.o_position, bus.o_blink_enb); end
    step(2);
    rst_n = 1'b1;
    bs = n_sec; bm = n_min; bh = n_hour;
    step(20);
    tests++; if ((n_sec - bs) + (n_min - bm) + (n_hour - bh) != 0 || bus.o_mode !== 1'b0) begin
      fails++; $display("FAIL held_after_reset: got %0d pulses mode=%0b want 0 0",
                        (n_sec - bs) + (n_min - bm) + (n_hour - bh), bus.o_mode); end
    sw2 = 1'b1; step(8);
    press_sw(0);
    bs = n_sec;
    press_sw(2);
    tests++; if (n_sec - bs != 1) begin fails++; $display("FAIL repress_after_reset: got %0d want 1", n_sec - bs); end
  endtask

  task automatic test_autorepeat;
    int bs, bm, bh, bd, exp;
`ifdef CLOCK_CTRL_AUTOREPEAT_EN
    exp = 5;
`else
    exp = 1;
`endif
    bs = n_sec; bm = n_min; bh = n_hour; bd = n_double;
    sw2 = 1'b0; step(40); sw2 = 1'b1; step(12);
    tests++; if (n_sec - bs != exp) begin fails++; $display("FAIL hold_sw2_sec: got %0d want %0d", n_sec - bs, exp); end
    tests++; if ((n_min - bm) + (n_hour - bh) != 0) begin
      fails++; $display("FAIL hold_sw2_other: got %0d want 0", (n_min - bm) + (n_hour - bh)); end
    tests++; if (n_double - bd != 0) begin fails++; $display("FAIL hold_sw2_double: got %0d want 0", n_double - bd); end
  endtask

  initial begin
    bus.i_tick_1hz = 1'b0;
    bus.i_sec_at_max = 1'b0;
    bus.i_min_at_max = 1'b0;
    test_reset();
    test_tick_clock();
    test_debounce_mode();
    test_setup_select();
    test_blink();
    test_back_to_back();
    test_reset_mid();
    test_autorepeat();
    tests++; if (n_double != 0) begin fails++; $display("FAIL no_double_pulse: got %0d want 0", n_double); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
